// File: rtl/newtons_method_rsqrt_iterative.sv
// newtons_method_rsqrt_iterative
//   Reciprocal square root by Newton iteration, g' = g*(3 - x*g*g) >>> 1,
//   computed on one shared multi-cycle fused multiply-add.
//   Also holds the fixed-point package and the FMA unit it drives so the
//   file stands alone.
//   Optional feature: define RSQRT_CONVERGENCE_EXIT_EN to stop iterating once
//   successive guesses differ by no more than 2^-TOLERANCE_SHIFT.

package ransac_fixed;
    localparam int VALUE_BITS = 32;
    localparam int FRAC_BITS  = 16;

    // Signed Q16.16
    typedef logic signed [VALUE_BITS-1:0] fixed_t;

    localparam fixed_t FIXED_MAX   = 32'sh7FFF_FFFF;
    localparam fixed_t FIXED_MIN   = 32'sh8000_0000;
    localparam fixed_t FIXED_ZERO  = 32'sh0000_0000;
    localparam fixed_t FIXED_THREE = 32'sh0003_0000;

    // bit0 negates the product, bit1 negates the addend
    typedef enum logic [1:0] {
        FMA_OPCODE_POS_A_POS_C = 2'd0,
        FMA_OPCODE_NEG_A_POS_C = 2'd1,
        FMA_OPCODE_POS_A_NEG_C = 2'd2,
        FMA_OPCODE_NEG_A_NEG_C = 2'd3
    } fma_opcode_t;

    function automatic int value_bits();
        return VALUE_BITS;
    endfunction

    // Clamp a wide intermediate into fixed_t range
    function automatic fixed_t saturate(input logic signed [63:0] v);
        if (v > 64'sh0000_0000_7FFF_FFFF)
            return FIXED_MAX;
        else if (v < 64'shFFFF_FFFF_8000_0000)
            return FIXED_MIN;
        else
            return v[VALUE_BITS-1:0];
    endfunction
endpackage

// Multi-cycle fused multiply-add: result = sat(round(+-a*b) +- c).
// The product is rounded half-up at the binary point before the add.
// One request in flight; output_valid is a one-cycle pulse multiply_latency
// cycles after the accepting cycle.
module slow_fp_fused_multiply_add #(
    parameter int multiply_latency = 2
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      input_valid,
    output logic                      input_ready,
    input  ransac_fixed::fixed_t      a,
    input  ransac_fixed::fixed_t      b,
    input  ransac_fixed::fixed_t      c,
    input  ransac_fixed::fma_opcode_t opcode,
    output logic                      output_valid,
    output ransac_fixed::fixed_t      result
);
    import ransac_fixed::*;

    localparam int CW = (multiply_latency > 1) ? $clog2(multiply_latency) : 1;

    logic                 busy;
    logic [CW-1:0]        count;
    logic signed [63:0]   a_w, b_w, c_w, prod, scaled, total;
    fixed_t               sum_d;

    // Full-precision multiply-add of the presented operands
    always_comb begin
        a_w    = {{(64-VALUE_BITS){a[VALUE_BITS-1]}}, a};
        b_w    = {{(64-VALUE_BITS){b[VALUE_BITS-1]}}, b};
        c_w    = {{(64-VALUE_BITS){c[VALUE_BITS-1]}}, c};
        prod   = a_w * b_w;
        if (opcode[0])
            prod = -prod;
        scaled = (prod + 64'sd32768) >>> FRAC_BITS;
        total  = opcode[1] ? (scaled - c_w) : (scaled + c_w);
        sum_d  = saturate(total);
    end

    // Latency counter; the answer is captured at accept and revealed later
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            busy   <= 1'b0;
            count  <= '0;
            result <= '0;
        end else if (input_valid && input_ready) begin
            busy   <= 1'b1;
            count  <= CW'(multiply_latency - 1);
            result <= sum_d;
        end else if (busy) begin
            if (count == '0)
                busy <= 1'b0;
            else
                count <= count - 1'b1;
        end
    end

    assign input_ready  = !busy;
    assign output_valid = busy && (count == '0);
endmodule

module newtons_method_rsqrt_iterative #(
    parameter int multiply_latency = ransac_fixed::value_bits() / 16,
    parameter int MAX_ITERATIONS   = 8,
    parameter int TOLERANCE_SHIFT  = 12
) (
    input  logic                                  clock,
    input  logic                                  reset,
    input  logic                                  input_valid,
    output logic                                  input_ready,
    input  ransac_fixed::fixed_t                  number,
    input  ransac_fixed::fixed_t                  seed,
    input  logic [$clog2(MAX_ITERATIONS+1)-1:0]   iterations,
    output logic                                  output_valid,
    input  logic                                  output_ready,
    output ransac_fixed::fixed_t                  result,
    output logic [$clog2(MAX_ITERATIONS+1)-1:0]   iterations_done,
    output logic                                  domain_error
);
    import ransac_fixed::*;

    localparam int IW = $clog2(MAX_ITERATIONS + 1);

    // Elaboration-time parameter sanity
    generate
        if (MAX_ITERATIONS < 1) begin : g_bad_max_iter
            $error("MAX_ITERATIONS must be at least 1");
        end
        if (TOLERANCE_SHIFT < 0 || TOLERANCE_SHIFT > FRAC_BITS) begin : g_bad_tol
            $error("TOLERANCE_SHIFT must lie within the fraction width");
        end
    endgenerate

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        CHECK  = 3'd1,
        FMA0   = 3'd2,
        FMA1   = 3'd3,
        FMA2   = 3'd4,
        UPDATE = 3'd5,
        DONE   = 3'd6
    } state_t;

    state_t          state, state_next;
    fixed_t          x_q, g_q, r_q;
    logic [IW-1:0]   n_q, k_q, k_inc;
    logic            issued;

    logic            fma_in_valid, fma_in_ready, fma_out_valid;
    fixed_t          fma_a, fma_b, fma_c, fma_result;

    fixed_t          g_new, neg_r, res_d;
    logic [IW-1:0]   done_d, n_clamped;
    logic            err_d, load_out, converged;

    assign n_clamped = (iterations > IW'(MAX_ITERATIONS)) ? IW'(MAX_ITERATIONS) : iterations;
    assign k_inc     = k_q + 1'b1;
    assign g_new     = r_q >>> 1;
    // -MIN does not exist in two's complement; pin it to MAX
    assign neg_r     = (r_q == FIXED_MIN) ? FIXED_MAX : -r_q;

`ifdef RSQRT_CONVERGENCE_EXIT_EN
    localparam logic [VALUE_BITS:0] TOL = (VALUE_BITS+1)'(1) << (FRAC_BITS - TOLERANCE_SHIFT);
    logic signed [VALUE_BITS:0] step;
    logic        [VALUE_BITS:0] step_mag;

    // One extra bit keeps the step between any two guesses exact
    always_comb begin
        step      = {g_new[VALUE_BITS-1], g_new} - {g_q[VALUE_BITS-1], g_q};
        step_mag  = step[VALUE_BITS] ? -step : step;
        converged = (step_mag <= TOL);
    end
`else
    assign converged = 1'b0;
`endif

    // Next state, FMA operand steering and DONE-entry values
    always_comb begin
        state_next   = state;
        fma_in_valid = 1'b0;
        fma_a        = x_q;
        fma_b        = g_q;
        fma_c        = FIXED_ZERO;
        load_out     = 1'b0;
        res_d        = g_q;
        done_d       = k_q;
        err_d        = 1'b0;
        case (state)
            IDLE: begin
                if (input_valid)
                    state_next = CHECK;
            end
            CHECK: begin
                if (x_q[VALUE_BITS-1] || x_q == FIXED_ZERO) begin
                    err_d      = 1'b1;
                    res_d      = FIXED_ZERO;
                    done_d     = '0;
                    load_out   = 1'b1;
                    state_next = DONE;
                end else if (n_q == '0) begin
                    load_out   = 1'b1;
                    state_next = DONE;
                end else begin
                    state_next = FMA0;
                end
            end
            FMA0: begin
                fma_in_valid = !issued && fma_in_ready;
                if (issued && fma_out_valid)
                    state_next = FMA1;
            end
            FMA1: begin
                fma_a        = neg_r;
                fma_c        = FIXED_THREE;
                fma_in_valid = !issued && fma_in_ready;
                if (issued && fma_out_valid)
                    state_next = FMA2;
            end
            FMA2: begin
                fma_a        = r_q;
                fma_in_valid = !issued && fma_in_ready;
                if (issued && fma_out_valid)
                    state_next = UPDATE;
            end
            UPDATE: begin
                if (k_inc == n_q || converged) begin
                    res_d      = g_new;
                    done_d     = k_inc;
                    load_out   = 1'b1;
                    state_next = DONE;
                end else begin
                    state_next = FMA0;
                end
            end
            DONE: begin
                if (output_ready)
                    state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset)
            state <= IDLE;
        else
            state <= state_next;
    end

    // Request latch, iteration state and FMA result capture
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            x_q    <= '0;
            g_q    <= '0;
            r_q    <= '0;
            n_q    <= '0;
            k_q    <= '0;
            issued <= 1'b0;
        end else begin
            if (state == IDLE && input_valid) begin
                x_q <= number;
                g_q <= seed;
                n_q <= n_clamped;
                k_q <= '0;
            end
            if (state_next != state)
                issued <= 1'b0;
            else if (fma_in_valid)
                issued <= 1'b1;
            if (issued && fma_out_valid)
                r_q <= fma_result;
            if (state == UPDATE) begin
                g_q <= g_new;
                k_q <= k_inc;
            end
        end
    end

    // Output registers: loaded on entry to DONE, held until accepted
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            output_valid    <= 1'b0;
            result          <= '0;
            iterations_done <= '0;
            domain_error    <= 1'b0;
        end else if (load_out) begin
            output_valid    <= 1'b1;
            result          <= res_d;
            iterations_done <= done_d;
            domain_error    <= err_d;
        end else if (output_valid && output_ready) begin
            output_valid    <= 1'b0;
        end
    end

    assign input_ready = (state == IDLE);

    slow_fp_fused_multiply_add #(
        .multiply_latency (multiply_latency)
    ) u_fma (
        .clock        (clock),
        .reset        (reset),
        .input_valid  (fma_in_valid),
        .input_ready  (fma_in_ready),
        .a            (fma_a),
        .b            (fma_b),
        .c            (fma_c),
        .opcode       (FMA_OPCODE_POS_A_POS_C),
        .output_valid (fma_out_valid),
        .result       (fma_result)
    );
endmodule
